// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage controller.
//   Issues in-order instruction-memory requests at the current pc and steers
//   the PC register through next_pc/pc_en. Responses are paired with the pc
//   saved at issue time and queued for decode. Redirects flush the queue and
//   discard every response still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a misaligned redirect target parks the fetcher in HALT and
//   raises fetch_misalign until an aligned redirect arrives. When undefined,
//   redirect targets are force-aligned and the fetcher is always running.
module fetch_ctrl #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_instr,
  output logic [31:0] fq_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  // Queue index/count widths; count needs one extra bit to represent "full".
  localparam int unsigned QAW = $clog2(QDEPTH);
  localparam int unsigned QCW = QAW + 1;
  // Occupancy (queue + in flight) gets a guard bit so the sum never wraps.
  localparam int unsigned OW  = QCW + 1;
  // In-flight / drop counters must hold the value MAX_OUTST itself.
  localparam int unsigned IW  = $clog2(MAX_OUTST) + 1;
  // In-flight PC FIFO pointer; a one-entry FIFO still needs a 1-bit index.
  localparam int unsigned FAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Storage arrays (data only, validity is tracked by the pointers/counts).
  logic [31:0] q_pc_mem_q    [QDEPTH];
  logic [31:0] q_instr_mem_q [QDEPTH];
  logic [31:0] f_pc_mem_q    [MAX_OUTST];

  logic [QAW-1:0] q_head_q, q_head_d;
  logic [QAW-1:0] q_tail_q, q_tail_d;
  logic [QCW-1:0] q_count_q, q_count_d;
  logic [FAW-1:0] f_wr_q, f_wr_d;
  logic [FAW-1:0] f_rd_q, f_rd_d;
  logic [IW-1:0]  inflight_cnt_q, inflight_cnt_d;
  logic [IW-1:0]  drop_cnt_q, drop_cnt_d;
  state_e         state_q, state_d;

  logic [OW-1:0]  occ_s;
  logic           credit_ok_s;
  logic           outst_ok_s;
  logic           req_valid_s;
  logic           req_fire_s;
  logic           resp_ok_s;
  logic           resp_keep_s;
  logic           pop_s;
  logic [31:0]    redirect_tgt_s;
  logic           unused_s;

  // RESET_PC only matters to whoever checks fq_pc; the low target bits are
  // ignored when misaligned targets are simply force-aligned.
  assign unused_s = ^{RESET_PC, redirect_pc[1:0]};

  // Issue/credit/response qualifiers shared by outputs and next-state logic.
  always_comb begin
    occ_s       = OW'(q_count_q) + OW'(inflight_cnt_q);
    credit_ok_s = (occ_s < OW'(QDEPTH));
    outst_ok_s  = (inflight_cnt_q < IW'(MAX_OUTST));
    req_valid_s = !rst && (state_q == ST_RUN) && !redirect_valid &&
                  (drop_cnt_q == '0) && credit_ok_s && outst_ok_s;
    req_fire_s  = req_valid_s && imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored.
    resp_ok_s   = imem_resp_valid && (inflight_cnt_q != '0);
    // A response landing in the redirect cycle belongs to the old stream.
    resp_keep_s = resp_ok_s && (drop_cnt_q == '0) && !redirect_valid;
    pop_s       = (q_count_q != '0) && fq_ready && !redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_tgt_s = redirect_pc;
`else
    redirect_tgt_s = {redirect_pc[31:2], 2'b00};
`endif
  end

  // PC steering and decode-facing outputs; everything is held low in reset.
  always_comb begin
    pc_en          = 1'b0;
    next_pc        = pc;
    imem_req_valid = req_valid_s;
    imem_req_addr  = pc;
    fq_valid       = 1'b0;
    fq_instr       = q_instr_mem_q[q_head_q];
    fq_pc          = q_pc_mem_q[q_head_q];
    if (rst) begin
      next_pc       = 32'h0000_0000;
      imem_req_addr = 32'h0000_0000;
      fq_instr      = 32'h0000_0000;
      fq_pc         = 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_en    = 1'b1;
      next_pc  = redirect_tgt_s;
      fq_valid = (q_count_q != '0);
    end else if (req_fire_s) begin
      pc_en    = 1'b1;
      next_pc  = pc + 32'd4;
      fq_valid = (q_count_q != '0);
    end else begin
      fq_valid = (q_count_q != '0);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = !rst && (state_q == ST_HALT);
`endif

  // Next-state for counters, pointers and the run/halt state.
  always_comb begin
    q_head_d       = q_head_q;
    q_tail_d       = q_tail_q;
    q_count_d      = q_count_q;
    f_wr_d         = f_wr_q;
    f_rd_d         = f_rd_q;
    inflight_cnt_d = inflight_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    state_d        = state_q;

    if (redirect_valid) begin
      // Flush: the queue and saved PCs are stale; count what must be dropped.
      q_head_d   = '0;
      q_tail_d   = '0;
      q_count_d  = '0;
      f_wr_d     = '0;
      f_rd_d     = '0;
      if (resp_ok_s) begin
        inflight_cnt_d = inflight_cnt_q - IW'(1);
        drop_cnt_d     = inflight_cnt_q - IW'(1);
      end else begin
        drop_cnt_d     = inflight_cnt_q;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_RUN;
      end
`else
      state_d = ST_RUN;
`endif
    end else begin
      if (req_fire_s) begin
        f_wr_d = (f_wr_q == FAW'(MAX_OUTST - 1)) ? '0 : (f_wr_q + FAW'(1));
      end else begin
        f_wr_d = f_wr_q;
      end
      if (req_fire_s && !resp_ok_s) begin
        inflight_cnt_d = inflight_cnt_q + IW'(1);
      end else if (!req_fire_s && resp_ok_s) begin
        inflight_cnt_d = inflight_cnt_q - IW'(1);
      end else begin
        inflight_cnt_d = inflight_cnt_q;
      end
      if (resp_ok_s && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - IW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (resp_keep_s) begin
        f_rd_d   = (f_rd_q == FAW'(MAX_OUTST - 1)) ? '0 : (f_rd_q + FAW'(1));
        q_tail_d = q_tail_q + QAW'(1);
      end else begin
        f_rd_d   = f_rd_q;
        q_tail_d = q_tail_q;
      end
      if (pop_s) begin
        q_head_d = q_head_q + QAW'(1);
      end else begin
        q_head_d = q_head_q;
      end
      if (resp_keep_s && !pop_s) begin
        q_count_d = q_count_q + QCW'(1);
      end else if (!resp_keep_s && pop_s) begin
        q_count_d = q_count_q - QCW'(1);
      end else begin
        q_count_d = q_count_q;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      state_d = state_q;
`else
      state_d = ST_RUN;
`endif
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_head_q       <= '0;
      q_tail_q       <= '0;
      q_count_q      <= '0;
      f_wr_q         <= '0;
      f_rd_q         <= '0;
      inflight_cnt_q <= '0;
      drop_cnt_q     <= '0;
      state_q        <= ST_RUN;
    end else begin
      q_head_q       <= q_head_d;
      q_tail_q       <= q_tail_d;
      q_count_q      <= q_count_d;
      f_wr_q         <= f_wr_d;
      f_rd_q         <= f_rd_d;
      inflight_cnt_q <= inflight_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      state_q        <= state_d;
    end
  end

  // Save the pc of every issued request so its response can be tagged.
  always_ff @(posedge clk) begin
    if (!rst && req_fire_s) begin
      f_pc_mem_q[f_wr_q] <= pc;
    end
  end

  // Write accepted responses, tagged with their saved pc, into the queue tail.
  always_ff @(posedge clk) begin
    if (!rst && resp_keep_s) begin
      q_pc_mem_q[q_tail_q]    <= f_pc_mem_q[f_rd_q];
      q_instr_mem_q[q_tail_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Models the PC register and an in-order instruction memory with selectable
// latency (or a hold) around the DUT. Build with +define+FETCH_MISALIGN_TRAP_EN
// to exercise the misalignment trap.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit hold_resp = 1'b0;

  logic [31:0] mem_addr_q [$];
  int          mem_due_q  [$];
  logic [31:0] req_log    [$];
  logic [31:0] fqpc_log   [$];
  logic [31:0] fqin_log   [$];

  fetch_ctrl #(
    .QDEPTH   (4),
    .MAX_OUTST(2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq_valid       (fq_valid),
    .fq_ready       (fq_ready),
    .fq_instr       (fq_instr),
    .fq_pc          (fq_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then update PC register and memory model.
  task automatic tick();
    logic        fire;
    logic        pop;
    logic        take;
    logic [31:0] npc;
    @(negedge clk);
    fire = imem_req_valid & imem_req_ready;
    pop  = fq_valid & fq_ready;
    take = imem_resp_valid;
    npc  = pc_en ? next_pc : pc;
    if (fire) begin
      req_log.push_back(imem_req_addr);
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(cyc + lat);
    end
    if (pop) begin
      fqpc_log.push_back(fq_pc);
      fqin_log.push_back(fq_instr);
    end
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (take && mem_addr_q.size() > 0) begin
      mem_addr_q.delete(0);
      mem_due_q.delete(0);
    end
    if (rst) begin
      pc = RESET_PC;
      mem_addr_q.delete();
      mem_due_q.delete();
      imem_resp_valid = 1'b0;
    end else begin
      pc = npc;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && !hold_resp) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_addr_q[0]);
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    fq_ready = 1'b1;
    hold_resp = 1'b0;
    lat = 1;
    tick();
    tick();
    rst = 1'b0;
    req_log.delete();
    fqpc_log.delete();
    fqin_log.delete();
    settle();
  endtask

  initial begin
    rst             = 1'b1;
    pc              = RESET_PC;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0000_0000;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0000_0000;
    fq_ready        = 1'b1;

    // Reset: outputs held low while rst is high.
    tick();
    tick();
    check_eq("rst_pc_en", pc_en, 1'b0);
    check_eq("rst_next_pc", next_pc, 32'h0);
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_fq_valid", fq_valid, 1'b0);
    rst = 1'b0;
    req_log.delete();
    fqpc_log.delete();
    fqin_log.delete();
    settle();

    // Streaming fetch with 1-cycle memory.
    check_eq("a_req_valid", imem_req_valid, 1'b1);
    check_eq("a_req_addr", imem_req_addr, 32'h0);
    check_eq("a_pc_en", pc_en, 1'b1);
    check_eq("a_next_pc", next_pc, 32'h4);
    check_eq("a_fq_valid", fq_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("a_misalign", fetch_misalign, 1'b0);
`endif
    tick();
    check_eq("b_req_addr", imem_req_addr, 32'h4);
    check_eq("b_next_pc", next_pc, 32'h8);
    check_eq("b_fq_valid", fq_valid, 1'b0);
    tick();
    check_eq("c_fq_valid", fq_valid, 1'b1);
    check_eq("c_fq_pc", fq_pc, RESET_PC);
    check_eq("c_fq_instr", fq_instr, instr_of(RESET_PC));
    for (int i = 0; i < 4; i++) tick();
    check_eq("s_req_cnt_ge3", 32'(req_log.size() >= 3), 32'h1);
    check_eq("s_fq_cnt_ge3", 32'(fqpc_log.size() >= 3), 32'h1);
    if (req_log.size() >= 3 && fqpc_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("s_req%0d", i), req_log[i], 32'(4 * i));
        check_eq($sformatf("s_fqpc%0d", i), fqpc_log[i], 32'(4 * i));
        check_eq($sformatf("s_fqin%0d", i), fqin_log[i], instr_of(32'(4 * i)));
      end
    end

    // Back-pressure: exactly QDEPTH requests, then resume after one pop.
    do_reset();
    fq_ready = 1'b0;
    settle();
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_req_cnt", 32'(req_log.size()), 32'd4);
    check_eq("bp_req_valid", imem_req_valid, 1'b0);
    check_eq("bp_fq_pc", fq_pc, 32'h0);
    fq_ready = 1'b1;
    settle();
    check_eq("bp_pop_cycle_valid", imem_req_valid, 1'b0);
    tick();
    fq_ready = 1'b0;
    settle();
    check_eq("bp_resume_valid", imem_req_valid, 1'b1);
    check_eq("bp_resume_addr", imem_req_addr, 32'h10);
    check_eq("bp_head_after_pop", fq_pc, 32'h4);
    // Redirect with a full-ish queue and a ready memory: flush, no request.
    fq_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    settle();
    check_eq("fl_req_valid", imem_req_valid, 1'b0);
    check_eq("fl_pc_en", pc_en, 1'b1);
    check_eq("fl_next_pc", next_pc, 32'h300);
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("fl_fq_valid", fq_valid, 1'b0);
    check_eq("fl_new_req", imem_req_valid, 1'b1);
    check_eq("fl_new_addr", imem_req_addr, 32'h300);

    // Redirect with two requests in flight: both responses dropped.
    do_reset();
    hold_resp = 1'b1;
    settle();
    tick();
    tick();
    check_eq("r2_outst_full", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    settle();
    check_eq("r2_next_pc", next_pc, 32'h100);
    tick();
    redirect_valid = 1'b0;
    hold_resp = 1'b0;
    settle();
    check_eq("r2_d_req_valid", imem_req_valid, 1'b0);
    tick();
    tick();
    check_eq("r2_f_req_valid", imem_req_valid, 1'b0);
    tick();
    check_eq("r2_g_req_valid", imem_req_valid, 1'b1);
    check_eq("r2_g_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 4; i++) tick();
    check_eq("r2_fq_nonempty", 32'(fqpc_log.size() > 0), 32'h1);
    if (fqpc_log.size() > 0) begin
      check_eq("r2_first_fq_pc", fqpc_log[0], 32'h100);
      check_eq("r2_first_fq_in", fqin_log[0], instr_of(32'h100));
    end

    // Redirect coinciding with a response: that response and one more dropped.
    do_reset();
    hold_resp = 1'b1;
    settle();
    tick();
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = instr_of(32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    hold_resp = 1'b0;
    settle();
    check_eq("rr_req_valid", imem_req_valid, 1'b0);
    check_eq("rr_next_pc", next_pc, 32'h200);
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("rr_d_req_valid", imem_req_valid, 1'b0);
    tick();
    check_eq("rr_e_req_valid", imem_req_valid, 1'b1);
    check_eq("rr_e_req_addr", imem_req_addr, 32'h200);
    for (int i = 0; i < 4; i++) tick();
    check_eq("rr_fq_nonempty", 32'(fqpc_log.size() > 0), 32'h1);
    if (fqpc_log.size() > 0) begin
      check_eq("rr_first_fq_pc", fqpc_log[0], 32'h200);
    end

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("wr_req_valid", imem_req_valid, 1'b1);
    check_eq("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check_eq("wr_next_pc", next_pc, 32'h0);
    tick();
    check_eq("wr_after_addr", imem_req_addr, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("wr_fq_nonempty", 32'(fqpc_log.size() > 0), 32'h1);
    if (fqpc_log.size() > 0) begin
      check_eq("wr_first_fq_pc", fqpc_log[0], 32'hFFFF_FFFC);
    end

    // Misaligned redirect target.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("ma_next_pc", next_pc, 32'h102);
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("ma_halt_flag", fetch_misalign, 1'b1);
    check_eq("ma_halt_noreq", imem_req_valid, 1'b0);
    tick();
    tick();
    check_eq("ma_halt_noreq2", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0305;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("ma_halt_stay", fetch_misalign, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    settle();
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("ma_run_flag", fetch_misalign, 1'b0);
    check_eq("ma_run_req", imem_req_valid, 1'b1);
    check_eq("ma_run_addr", imem_req_addr, 32'h200);
`else
    check_eq("ma_next_pc", next_pc, 32'h100);
    tick();
    redirect_valid = 1'b0;
    settle();
    check_eq("ma_req_valid", imem_req_valid, 1'b1);
    check_eq("ma_req_addr", imem_req_addr, 32'h100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
